// File: rtl/memory_responder.sv
// Word-organised RAM endpoint for the memory request handshake: one request at a
// time, programmable access latency, four-phase enable/ready with fault reporting.
module memory_responder #(
    parameter int SIZE        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            memory_enable,
    input  logic            memory_operation,
    output logic            memory_ready,
    input  logic [1:0]      memory_data_size,
    input  logic [SIZE-1:0] memory_address,
    output logic [SIZE-1:0] memory_data_in,
    input  logic [SIZE-1:0] memory_data_out,
    output logic            memory_fault
);

    localparam int         IDXW = $clog2(DEPTH_WORDS);
    localparam logic [7:0] LAT  = 8'(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [7:0]      cnt_q;
    logic            op_q;
    logic [1:0]      size_q;
    logic [SIZE-1:0] addr_q;
    logic [SIZE-1:0] wdata_q;
    logic            ready_q;
    logic            fault_q;
    logic [SIZE-1:0] rdata_q;

    logic [SIZE-1:0] mem_q [DEPTH_WORDS];

    logic [IDXW-1:0] idx;
    logic [SIZE-1:0] word;
    logic            access;
    logic            commit;
    logic            fault_d;
    logic [SIZE-1:0] rdata_d;
    logic [SIZE-1:0] lane_data;
    logic [3:0]      lane_en;

    assign idx    = addr_q[IDXW+1:2];
    assign word   = mem_q[idx];
    assign access = (state_q == BUSY) && (cnt_q == 8'd0);
    // A reset landing on the access edge must discard the pending write.
    assign commit = access && op_q && !fault_d && !reset;

    always_comb begin
        case (size_q)
            2'd0:    fault_d = 1'b0;
            2'd1:    fault_d = addr_q[0];
            2'd2:    fault_d = |addr_q[1:0];
            default: fault_d = 1'b1;
        endcase
        if (|addr_q[SIZE-1:IDXW+2]) fault_d = 1'b1;
    end

    // Byte/half data is replicated across lanes so the lane enables alone pick the target.
    always_comb begin
        rdata_d   = '0;
        lane_en   = 4'b0000;
        lane_data = wdata_q;
        case (size_q)
            2'd0: begin
                rdata_d   = {24'd0, word[8*addr_q[1:0] +: 8]};
                lane_en   = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                rdata_d   = {16'd0, word[16*addr_q[1] +: 16]};
                lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            2'd2: begin
                rdata_d = word;
                lane_en = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem_q[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memory_enable) begin
                        op_q    <= memory_operation;
                        size_q  <= memory_data_size;
                        addr_q  <= memory_address;
                        wdata_q <= memory_data_out;
                        cnt_q   <= LAT;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        ready_q <= 1'b1;
                        fault_q <= fault_d;
                        rdata_q <= (fault_d || op_q) ? '0 : rdata_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Read data survives the release so the initiator may sample it late.
                    if (!memory_enable) begin
                        ready_q <= 1'b0;
                        fault_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memory_ready   = ready_q;
    assign memory_fault   = fault_q;
    assign memory_data_in = rdata_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomised bench for memory_responder: three instances (LATENCY 0, 1, 5) checked
// every cycle against a word-array model with a per-request expected timeline.
module tb_memory_responder;

    localparam int DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  en, op, rdy, flt;
    logic [1:0]  sz  [3];
    logic [31:0] adr [3];
    logic [31:0] wdo [3];
    logic [31:0] din [3];

    always #5 clock = ~clock;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gd
            memory_responder #(
                .SIZE(32),
                .DEPTH_WORDS(DEPTH),
                .LATENCY(g == 0 ? 0 : (g == 1 ? 1 : 5))
            ) dut (
                .clock(clock),
                .reset(reset),
                .memory_enable(en[g]),
                .memory_operation(op[g]),
                .memory_ready(rdy[g]),
                .memory_data_size(sz[g]),
                .memory_address(adr[g]),
                .memory_data_in(din[g]),
                .memory_data_out(wdo[g]),
                .memory_fault(flt[g])
            );
        end
    endgenerate

    logic [31:0] mm [3][32];
    logic [2:0]  e_rdy, e_flt;
    logic [31:0] e_dat [3];
    int          total = 0;
    int          bad   = 0;
    bit          mon_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int latof(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 5);
    endfunction

    function automatic bit mfault(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0)
               || ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] mread(input int d, input logic [1:0] s, input logic [31:0] a);
        logic [31:0] w, sh;
        w  = mm[d][a[6:2]];
        sh = w >> (8 * a[1:0]);
        if (s == 2'd0) return sh & 32'h0000_00FF;
        if (s == 2'd1) return sh & 32'h0000_FFFF;
        return w;
    endfunction

    task automatic mwrite(input int d, input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
        int n, base;
        n    = (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
        base = (s == 2'd2) ? 0 : int'(a[1:0]);
        for (int i = 0; i < n; i++) mm[d][a[6:2]][8*(base+i) +: 8] = w[8*i +: 8];
    endtask

    always @(negedge clock) begin
        if (mon_on) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("ready%0d", d), 32'(rdy[d]), 32'(e_rdy[d]));
                chk($sformatf("fault%0d", d), 32'(flt[d]), 32'(e_flt[d]));
                chk($sformatf("data_in%0d", d), din[d], e_dat[d]);
            end
        end
    end

    // Full four-phase transaction; lat is the edge count from enable sampling to ready seen.
    task automatic xact(input int d, input bit o, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] w, input int hold, input bit drop,
                        output int lat, output bit rflt, output logic [31:0] rdat);
        bit          f;
        logic [31:0] r;
        int          L;
        L = latof(d);
        f = mfault(s, a);
        r = (f || o) ? 32'd0 : mread(d, s, a);
        en[d] = 1'b1; op[d] = o; sz[d] = s; adr[d] = a; wdo[d] = w;
        lat = -1; rflt = 1'b0; rdat = 32'd0;
        for (int c = 0; c <= L + 1; c++) begin
            @(posedge clock); #1;
            if (c == 0) begin
                op[d]  = 1'($urandom);
                sz[d]  = 2'($urandom);
                adr[d] = $urandom;
                wdo[d] = $urandom;
                if (drop) en[d] = 1'b0;
            end
            if (rdy[d] && lat < 0) lat = c;
            if (c == L + 1) begin
                e_rdy[d] = 1'b1; e_flt[d] = f; e_dat[d] = r;
                rflt = flt[d]; rdat = din[d];
                if (o && !f) mwrite(d, s, a, w);
            end
        end
        if (!drop) repeat (hold) begin @(posedge clock); #1; end
        en[d] = 1'b0;
        @(posedge clock); #1;
        e_rdy[d] = 1'b0; e_flt[d] = 1'b0;
    endtask

    task automatic rst_mid(input int d, input logic [31:0] a, input logic [31:0] w);
        int L;
        L = latof(d);
        en[d] = 1'b1; op[d] = 1'b1; sz[d] = 2'd2; adr[d] = a; wdo[d] = w;
        for (int c = 0; c <= L; c++) begin
            @(posedge clock); #1;
            en[d] = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin e_rdy[i] = 1'b0; e_flt[i] = 1'b0; e_dat[i] = 32'd0; end
        chk($sformatf("rst_mid_ready%0d", d), 32'(rdy[d]), 32'd0);
    endtask

    initial begin
        int          lat;
        bit          rf;
        logic [31:0] rd;
        reset = 1'b1;
        en = 3'b000; op = 3'b000;
        for (int d = 0; d < 3; d++) begin
            sz[d] = 2'd0; adr[d] = 32'd0; wdo[d] = 32'd0;
            e_rdy[d] = 1'b0; e_flt[d] = 1'b0; e_dat[d] = 32'd0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ready%0d", d), 32'(rdy[d]), 32'd0);
            chk($sformatf("reset_fault%0d", d), 32'(flt[d]), 32'd0);
            chk($sformatf("reset_data%0d", d), din[d], 32'd0);
        end
        mon_on = 1'b1;

        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 32; i++)
                xact(d, 1'b1, 2'd2, 32'(4 * i), $urandom, 0, 1'b0, lat, rf, rd);

        xact(1, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, lat, rf, rd);
        chk("lat_L1", 32'(lat), 32'd2);
        chk("ww_fault", 32'(rf), 32'd0);
        xact(1, 1'b1, 2'd0, 32'h20, 32'h0000_0011, 0, 1'b0, lat, rf, rd);
        xact(1, 1'b1, 2'd0, 32'h21, 32'hFFFF_FF22, 0, 1'b0, lat, rf, rd);
        xact(1, 1'b1, 2'd1, 32'h22, 32'h1234_BEEF, 0, 1'b0, lat, rf, rd);
        xact(1, 1'b0, 2'd2, 32'h20, 32'h0, 0, 1'b0, lat, rf, rd);
        chk("lanes_word", rd, 32'hBEEF_2211);
        chk("lanes_kept", din[1], 32'hBEEF_2211);
        xact(1, 1'b0, 2'd0, 32'h23, 32'h0, 0, 1'b0, lat, rf, rd);
        chk("byte_read", rd, 32'h0000_00BE);
        xact(1, 1'b0, 2'd1, 32'h22, 32'h0, 0, 1'b0, lat, rf, rd);
        chk("half_read", rd, 32'h0000_BEEF);
        xact(1, 1'b0, 2'd2, 32'h10, 32'h0, 0, 1'b1, lat, rf, rd);
        chk("drop_busy", rd, 32'hDEAD_BEEF);

        xact(1, 1'b1, 2'd2, 32'h0, 32'hA5A5_A5A5, 0, 1'b0, lat, rf, rd);
        xact(1, 1'b0, 2'd1, 32'h21, 32'h0, 0, 1'b0, lat, rf, rd);
        chk("half_mis_fault", 32'(rf), 32'd1);
        chk("half_mis_data", rd, 32'd0);
        xact(1, 1'b0, 2'd2, 32'h22, 32'h0, 0, 1'b0, lat, rf, rd);
        chk("word_mis_fault", 32'(rf), 32'd1);
        xact(1, 1'b1, 2'd3, 32'h0, 32'h1111_1111, 0, 1'b0, lat, rf, rd);
        chk("size3_fault", 32'(rf), 32'd1);
        xact(1, 1'b1, 2'd2, 32'(DEPTH * 4), 32'h1234_5678, 0, 1'b0, lat, rf, rd);
        chk("range_fault", 32'(rf), 32'd1);
        chk("range_data", rd, 32'd0);
        xact(1, 1'b0, 2'd2, 32'h0, 32'h0, 0, 1'b0, lat, rf, rd);
        chk("no_change", rd, 32'hA5A5_A5A5);

        xact(0, 1'b0, 2'd2, 32'h10, 32'h0, 0, 1'b0, lat, rf, rd);
        chk("lat_L0", 32'(lat), 32'd1);
        xact(2, 1'b1, 2'd2, 32'h14, 32'h0BAD_CAFE, 3, 1'b0, lat, rf, rd);
        chk("lat_L5", 32'(lat), 32'd6);
        xact(2, 1'b0, 2'd2, 32'h14, 32'h0, 3, 1'b0, lat, rf, rd);
        chk("hold_read", rd, 32'h0BAD_CAFE);

        for (int d = 0; d < 3; d++) begin
            rst_mid(d, 32'h40, 32'hCAFE_F00D);
            xact(d, 1'b0, 2'd2, 32'h40, 32'h0, 0, 1'b0, lat, rf, rd);
            chk($sformatf("rst_keep%0d", d), rd, mm[d][16]);
        end

        for (int i = 0; i < 40; i++)
            xact(1, 1'b1 ^ 1'(i), 2'(i % 3), 32'(8 * (i % 2) + 4 * (i % 3)), $urandom, 0, 1'b0, lat, rf, rd);

        for (int i = 0; i < 200; i++) begin
            int          d, pick;
            logic [31:0] a;
            logic [1:0]  s;
            d    = int'($urandom_range(0, 2));
            pick = int'($urandom_range(0, 19));
            s    = (pick == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (pick == 1) a = 32'h0000_1000 | $urandom;
            else           a = 32'($urandom_range(0, 127));
            xact(d, 1'($urandom), s, a, $urandom, int'($urandom_range(0, 2)),
                 ($urandom_range(0, 3) == 0), lat, rf, rd);
            chk("rand_lat", 32'(lat), 32'(latof(d) + 1));
        end

        repeat (2) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
